// File: rtl/matrix_stream.sv
`default_nettype none
// ============================================================================
// Module   : matrix_stream
// Purpose  : M x N register matrix, loaded in one cycle from a flat bus and
//            streamed one element per valid/ready beat, row- or column-major.
//            Optional single-element write port: MATRIX_STREAM_WRITE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_stream #(
    parameter int nBits = 32,
    parameter int M     = 32,
    parameter int N     = 16,
    localparam int RW   = (M > 1) ? $clog2(M) : 1,
    localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [M*N*nBits-1:0]   A_in,
    input  logic                   load,
    input  logic                   start,
    input  logic                   transpose,
    input  logic                   out_ready,
`ifdef MATRIX_STREAM_WRITE_EN
    input  logic                   wr_en,
    input  logic [RW-1:0]          wr_row,
    input  logic [CW-1:0]          wr_col,
    input  logic [nBits-1:0]       wr_data,
`endif
    output logic [nBits-1:0]       out_data,
    output logic                   out_valid,
    output logic [RW-1:0]          out_row,
    output logic [CW-1:0]          out_col,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    localparam int c_ELEMS = M * N;
    localparam int c_AW    = (c_ELEMS > 1) ? $clog2(c_ELEMS) : 1;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [nBits-1:0] r_mem [0:c_ELEMS-1];
    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic             r_trans;
    logic             r_done;

    logic             w_run;
    logic             w_accept;
    logic             w_row_end;
    logic             w_col_end;
    logic             w_last;
    logic [c_AW-1:0]  w_rd_idx;

    assign w_run     = (r_state == c_RUN);
    assign w_accept  = w_run & out_ready;
    assign w_row_end = (r_row == RW'(M - 1));
    assign w_col_end = (r_col == CW'(N - 1));
    assign w_last    = w_row_end & w_col_end;
    assign w_rd_idx  = c_AW'(r_row) * c_AW'(N) + c_AW'(r_col);

`ifdef MATRIX_STREAM_WRITE_EN
    logic            w_wr_ok;
    logic [c_AW-1:0] w_wr_idx;

    // Out-of-range indices are possible when M or N is not a power of two.
    assign w_wr_ok  = wr_en
                    & ({1'b0, wr_row} < (RW+1)'(M))
                    & ({1'b0, wr_col} < (CW+1)'(N));
    assign w_wr_idx = c_AW'(wr_row) * c_AW'(N) + c_AW'(wr_col);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = c_RUN;
            c_RUN:   if (w_accept && w_last) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_ELEMS; i++) r_mem[i] <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_trans <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!w_run) begin
                // Storage writes land before a same-cycle start, so the run sees them.
                if (load) begin
                    for (int i = 0; i < c_ELEMS; i++)
                        r_mem[i] <= A_in[(c_ELEMS-1-i)*nBits +: nBits];
                end
`ifdef MATRIX_STREAM_WRITE_EN
                else if (w_wr_ok) begin
                    r_mem[w_wr_idx] <= wr_data;
                end
`endif
                if (start) begin
                    r_trans <= transpose;
                    r_row   <= '0;
                    r_col   <= '0;
                end
            end else if (w_accept) begin
                if (w_last) begin
                    r_row  <= '0;
                    r_col  <= '0;
                    r_done <= 1'b1;
                end else if (!r_trans) begin
                    if (w_col_end) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end else begin
                    if (w_row_end) begin
                        r_row <= '0;
                        r_col <= r_col + 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end
            end
        end
    end

    assign out_valid = w_run;
    assign out_data  = w_run ? r_mem[w_rd_idx] : '0;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_last  = w_run & w_last;
    assign busy      = w_run;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_stream
// Purpose  : Directed scoreboard bench for matrix_stream (M=2, N=3, nBits=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_stream;

    localparam int c_M = 2;
    localparam int c_N = 3;
    localparam int c_B = 8;

    typedef struct packed {
        logic [7:0] d;
        logic       r;
        logic [1:0] c;
        logic       l;
    } beat_t;

    logic                     clk;
    logic                     rst;
    logic [c_M*c_N*c_B-1:0]   A_in;
    logic                     load;
    logic                     start;
    logic                     transpose;
    logic                     out_ready;
    logic [c_B-1:0]           out_data;
    logic                     out_valid;
    logic [0:0]               out_row;
    logic [1:0]               out_col;
    logic                     out_last;
    logic                     busy;
    logic                     done;
`ifdef MATRIX_STREAM_WRITE_EN
    logic                     wr_en;
    logic [0:0]               wr_row;
    logic [1:0]               wr_col;
    logic [c_B-1:0]           wr_data;
`endif

    matrix_stream #(.nBits(c_B), .M(c_M), .N(c_N)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .A_in      (A_in),
        .load      (load),
        .start     (start),
        .transpose (transpose),
        .out_ready (out_ready),
`ifdef MATRIX_STREAM_WRITE_EN
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    beat_t       q[$];
    logic [7:0]  a_mdl [0:5];
    logic [7:0]  mm    [0:5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_data"},  32'(out_data),  32'd0);
        chk({tag, "_row"},   32'(out_row),   32'd0);
        chk({tag, "_col"},   32'(out_col),   32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
    endtask

    task automatic set_a(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                         input logic [7:0] v3, input logic [7:0] v4, input logic [7:0] v5);
        a_mdl[0] = v0; a_mdl[1] = v1; a_mdl[2] = v2;
        a_mdl[3] = v3; a_mdl[4] = v4; a_mdl[5] = v5;
        for (int i = 0; i < 6; i++) A_in[(5-i)*8 +: 8] = a_mdl[i];
    endtask

    // Expected beat order is built from the element coordinates, not from the DUT.
    task automatic push_run(input bit tr);
        beat_t b;
        int    r;
        int    c;
        for (int o = 0; o < (tr ? c_N : c_M); o++) begin
            for (int i = 0; i < (tr ? c_M : c_N); i++) begin
                r   = tr ? i : o;
                c   = tr ? o : i;
                b.d = mm[r*c_N + c];
                b.r = r[0];
                b.c = c[1:0];
                b.l = (r == c_M-1) && (c == c_N-1);
                q.push_back(b);
            end
        end
    endtask

    task automatic start_run(input bit ld, input bit tr);
        load      = ld;
        start     = 1'b1;
        transpose = tr;
        if (ld) mm = a_mdl;
        push_run(tr);
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        chk("start_valid", 32'(out_valid), 32'd1);
        chk("start_busy",  32'(busy),      32'd1);
        chk("start_done",  32'(done),      32'd0);
    endtask

    task automatic drain(input bit bp, input int inj);
        int    cyc  = 0;
        bit    hold = 1'b0;
        beat_t prev = '0;
        beat_t cur;
        beat_t e;
        logic  rdy;
        while (q.size() > 0 && cyc < 60) begin
            rdy       = bp ? (cyc % 3 == 0) : 1'b1;
            out_ready = rdy;
            cur       = {out_data, out_row, out_col, out_last};
            chk("run_valid", 32'(out_valid), 32'd1);
            chk("run_done",  32'(done),      32'd0);
            if (hold) chk("hold_stable", 32'(cur), 32'(prev));
            if (rdy) begin
                e = q.pop_front();
                chk("beat", 32'(cur), 32'(e));
            end
            hold = !rdy;
            prev = cur;
            if (cyc == 2 && inj == 1) begin
                load      = 1'b1;
                start     = 1'b1;
                transpose = ~transpose;
                set_a(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
            end
`ifdef MATRIX_STREAM_WRITE_EN
            if (cyc == 2 && inj == 2) begin
                wr_en   = 1'b1;
                wr_row  = 1'b0;
                wr_col  = 2'd0;
                wr_data = 8'h55;
            end
            if (cyc == 3) wr_en = 1'b0;
`endif
            if (cyc == 3) begin
                load  = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        q.delete();
        out_ready = 1'b0;
        chk("end_done",  32'(done),      32'd1);
        chk("end_valid", 32'(out_valid), 32'd0);
        chk("end_busy",  32'(busy),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        A_in      = '0;
        load      = 1'b0;
        start     = 1'b0;
        transpose = 1'b0;
        out_ready = 1'b0;
`ifdef MATRIX_STREAM_WRITE_EN
        wr_en     = 1'b0;
        wr_row    = '0;
        wr_col    = '0;
        wr_data   = '0;
`endif
        for (int i = 0; i < 6; i++) mm[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("idle");

        // Row-major, then column-major started in the done cycle.
        set_a(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
        start_run(1'b1, 1'b0);
        drain(1'b0, 0);
        start_run(1'b0, 1'b1);
        drain(1'b0, 0);
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);

        // Backpressure: ready pattern 1,0,0 repeating.
        start_run(1'b0, 1'b0);
        drain(1'b1, 0);
        start_run(1'b0, 1'b1);
        drain(1'b1, 0);

        // Controls pulsed mid-run are ignored; the FF data appears only after a load.
        start_run(1'b0, 1'b0);
        drain(1'b0, 1);
        transpose = 1'b0;
        @(negedge clk);
        start_run(1'b1, 1'b0);
        drain(1'b0, 0);

`ifdef MATRIX_STREAM_WRITE_EN
        set_a(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        mm   = a_mdl;
        wr_en   = 1'b1;
        wr_row  = 1'b1;
        wr_col  = 2'd1;
        wr_data = 8'hAA;
        mm[4]   = 8'hAA;
        start_run(1'b0, 1'b0);
        wr_en = 1'b0;
        drain(1'b0, 2);
        // Column index 3 is out of range for N=3 and must not alias onto (1,0).
        wr_en   = 1'b1;
        wr_row  = 1'b0;
        wr_col  = 2'd3;
        wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        start_run(1'b0, 1'b0);
        drain(1'b0, 0);
`endif

        // Asynchronous reset in the middle of a run.
        set_a(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);
        start_run(1'b1, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_quiet("async_rst");
        q.delete();
        for (int i = 0; i < 6; i++) mm[i] = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_rst");
        start_run(1'b0, 1'b0);
        drain(1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
